// File: rtl/axi_lite_rng_multi.sv
// AXI4-Lite peripheral with NUM_CH Galois LFSR channels, each with a FIFO of pre-generated words.
// Optional macro RNG_IRQ_EN adds the irq output and makes CTRL bit1 (IRQ_EN) writable.
module axi_lite_rng_multi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CH             = 4,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
`ifdef RNG_IRQ_EN
  ,output logic                             irq
`endif
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DW-1:0] TAPS = 32'h8020_0003;
`ifdef RNG_IRQ_EN
  localparam logic [1:0] CTRL_MASK = 2'b11;
`else
  localparam logic [1:0] CTRL_MASK = 2'b01;
`endif

  logic [1:0]    ctrl;
  logic [7:0]    underflow;
  logic [7:0]    empty_v, full_v;
  logic [DW-1:0] lfsr     [NUM_CH];
  logic [DW-1:0] seed_v   [NUM_CH];
  logic [PW-1:0] wr_ptr   [NUM_CH];
  logic [PW-1:0] rd_ptr   [NUM_CH];
  logic [CW-1:0] count    [NUM_CH];
  logic [DW-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0] seed_hit, pop_req, push_v, pop_v;
  logic [DW-1:0] rd_mux;
  logic          wr_hs, rd_hs;
  logic          unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  function automatic logic addr_is(input logic [AW-1:0] a, input int off);
    return a[AW-1:2] == off[AW-1:2];
  endfunction

  // Handshakes: a transfer happens on any rising edge where valid and ready are both high.
  // AW/W ready pulse together once per write and only while no response is pending; AR ready
  // pulses once per read and only while no read data is pending. B/R valid hold until taken.
  assign wr_hs = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs = S_AXI_ARREADY & S_AXI_ARVALID;

  always_comb begin
    empty_v  = '0;
    full_v   = '0;
    seed_hit = '0;
    pop_req  = '0;
    push_v   = '0;
    pop_v    = '0;
    rd_mux   = '0;
    if (addr_is(S_AXI_ARADDR, 'h00))
      rd_mux = {{(DW-2){1'b0}}, ctrl};
    for (int c = 0; c < NUM_CH; c++) begin
      empty_v[c]  = (count[c] == '0);
      full_v[c]   = (count[c] == CW'(FIFO_DEPTH));
      seed_hit[c] = wr_hs && addr_is(S_AXI_AWADDR, 'h10 + 4 * c);
      pop_req[c]  = rd_hs && addr_is(S_AXI_ARADDR, 'h40 + 4 * c);
      // A seed write flushes the FIFO, so it suppresses both the push and the pop bookkeeping.
      push_v[c]   = ctrl[0] && !full_v[c] && !seed_hit[c];
      pop_v[c]    = pop_req[c] && !empty_v[c] && !seed_hit[c];
      if (addr_is(S_AXI_ARADDR, 'h40 + 4 * c) && !empty_v[c])
        rd_mux = fifo_mem[c][rd_ptr[c]];
    end
    if (addr_is(S_AXI_ARADDR, 'h04))
      rd_mux = {8'h00, underflow, full_v, empty_v};
  end

  // Seed bytes without a strobe keep the current LFSR byte; an all-zero result would lock up.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      seed_v[c] = lfsr[c];
      for (int b = 0; b < DW / 8; b++)
        if (S_AXI_WSTRB[b]) seed_v[c][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      if (seed_v[c] == '0) seed_v[c] = DW'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
      ctrl          <= '0;
      underflow     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr[c]   <= DW'(1);
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
      S_AXI_WREADY  <= ~S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_RRESP   <= 2'b00;
      if (wr_hs)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;

      S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID & ~S_AXI_RVALID;
      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end

      if (wr_hs && addr_is(S_AXI_AWADDR, 'h00) && S_AXI_WSTRB[0])
        ctrl <= S_AXI_WDATA[1:0] & CTRL_MASK;
      if (wr_hs && addr_is(S_AXI_AWADDR, 'h04) && S_AXI_WSTRB[2])
        underflow <= underflow & ~S_AXI_WDATA[23:16];

      for (int c = 0; c < NUM_CH; c++) begin
        if (pop_req[c] && empty_v[c])
          underflow[c] <= 1'b1;
        if (seed_hit[c]) begin
          lfsr[c]      <= seed_v[c];
          wr_ptr[c]    <= '0;
          rd_ptr[c]    <= '0;
          count[c]     <= '0;
          underflow[c] <= 1'b0;
        end else begin
          if (push_v[c]) begin
            wr_ptr[c] <= wr_ptr[c] + 1'b1;
            lfsr[c]   <= lfsr[c][0] ? ((lfsr[c] >> 1) ^ TAPS) : (lfsr[c] >> 1);
          end
          if (pop_v[c])
            rd_ptr[c] <= rd_ptr[c] + 1'b1;
          if (push_v[c] && !pop_v[c])
            count[c] <= count[c] + 1'b1;
          else if (pop_v[c] && !push_v[c])
            count[c] <= count[c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push_v[c]) fifo_mem[c][wr_ptr[c]] <= lfsr[c];
  end

`ifdef RNG_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) irq <= 1'b0;
    else          irq <= ctrl[1] & (|full_v);
  end
`endif

endmodule

// File: tb/tb_axi_lite_rng_multi.sv
// Self-checking bench for axi_lite_rng_multi (NUM_CH=4, FIFO_DEPTH=8); irq checks build with RNG_IRQ_EN.
module tb_axi_lite_rng_multi;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef RNG_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  axi_lite_rng_multi #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
`ifdef RNG_IRQ_EN
    ,.irq(irq)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] lfsr_word(input logic [31:0] seed, input int n);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = lfsr_next(s);
    return s;
  endfunction

  // driver tasks
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    check("awready", {31'b0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    check("bvalid", {31'b0, bvalid}, 32'd1);
    check("bresp", {30'b0, bresp}, 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    check("arready", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    check("rvalid", {31'b0, rvalid}, 32'd1);
    check("rresp", {30'b0, rresp}, 32'd0);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, rdata, e);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin : main
    logic [31:0] s3, st, seq;
    int idx [NUM_CH];
    int n, ch;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    axi_read("rst_ctrl", 8'h00, 32'h0000_0000);
    axi_read("rst_status", 8'h04, 32'h0000_000F);

    // known sequence from seed 1
    axi_write(8'h10, 32'h0000_0001, 4'hF);
    axi_write(8'h00, 32'h0000_0001, 4'hF);
    repeat (20) @(posedge clk);
    axi_read("status_full", 8'h04, 32'h0000_0F00);
    axi_read("ch0_w0", 8'h40, 32'h0000_0001);
    axi_read("ch0_w1", 8'h40, 32'h8020_0003);
    axi_read("ch0_w2", 8'h40, 32'hC030_0002);

    // drain ch1 with generation off, then underflow and write-1-to-clear
    axi_write(8'h00, 32'h0000_0000, 4'hF);
    for (int i = 0; i < DEPTH; i++) axi_read($sformatf("ch1_w%0d", i), 8'h44, lfsr_word(32'd1, i));
    axi_read("ch1_underflow_data", 8'h44, 32'h0000_0000);
    axi_read("status_uf", 8'h04, 32'h0002_0D02);
    axi_write(8'h04, 32'h0002_0000, 4'hF);
    axi_read("status_w1c", 8'h04, 32'h0000_0D02);

    // seeds: zero maps to 1, distinct seeds, partial strobe merge with current state
    s3 = lfsr_word(32'd1, DEPTH);
    s3[7:0] = 8'hAB;
    axi_write(8'h14, 32'h0000_0000, 4'hF);
    axi_write(8'h18, 32'h1234_5678, 4'hF);
    axi_write(8'h1C, 32'h0000_00AB, 4'h1);
    axi_write(8'h00, 32'h0000_0001, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(8'h00, 32'h0000_0000, 4'hF);
    axi_read("seed0_maps_to_1", 8'h44, 32'h0000_0001);
    axi_read("ch2_first", 8'h48, 32'h1234_5678);
    axi_read("ch2_second", 8'h48, lfsr_next(32'h1234_5678));
    axi_read("ch3_strb_seed", 8'h4C, s3);
    axi_read("status_after_seed", 8'h04, 32'h0000_0100);
    axi_write(8'h00, 32'h0000_0001, 4'h0);
    axi_read("ctrl_no_strobe", 8'h00, 32'h0000_0000);
    axi_read("unmapped_08", 8'h08, 32'h0000_0000);
    axi_read("unmapped_80", 8'h80, 32'h0000_0000);
    axi_read("absent_ch4", 8'h50, 32'h0000_0000);

`ifdef RNG_IRQ_EN
    axi_write(8'h00, 32'h0000_0003, 4'hF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("irq_full", {31'b0, irq}, 32'd1);
    axi_read("irq_ch0_pop", 8'h40, lfsr_word(32'd1, 3));
    @(negedge clk);
    check("irq_hold", {31'b0, irq}, 32'd1);
    axi_write(8'h00, 32'h0000_0001, 4'hF);
    @(negedge clk);
    check("irq_off", {31'b0, irq}, 32'd0);
`else
    axi_write(8'h00, 32'h0000_0003, 4'hF);
    axi_read("ctrl_bit1_masked", 8'h00, 32'h0000_0001);
`endif

    // reset while a write response is pending
    @(posedge clk); #1;
    awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_pending", {31'b0, bvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("bvalid_async_clear", {31'b0, bvalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_read("post_rst_ctrl", 8'h00, 32'h0000_0000);
    axi_read("post_rst_status", 8'h04, 32'h0000_000F);

    // random pops from full, frozen FIFOs
    axi_write(8'h00, 32'h0000_0001, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(8'h00, 32'h0000_0000, 4'hF);
    for (int c = 0; c < NUM_CH; c++) idx[c] = 0;
    for (int i = 0; i < 24; i++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      seq = (idx[ch] < DEPTH) ? lfsr_word(32'd1, idx[ch]) : 32'h0;
      axi_read($sformatf("rand_ch%0d_%0d", ch, idx[ch]), 8'h40 + 8'(4 * ch), seq);
      idx[ch]++;
    end
    st = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx[c] >= DEPTH) st[c] = 1'b1;
      if (idx[c] == 0)     st[8 + c] = 1'b1;
      if (idx[c] > DEPTH)  st[16 + c] = 1'b1;
    end
    axi_read("rand_status", 8'h04, st);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_lite_rng_multi.md
Name: axi_lite_rng_multi

Overview:
- AXI4-Lite slave peripheral with NUM_CH independent 32-bit Galois LFSR random number channels.
- Each channel has a FIFO of pre-generated words, a software-writable seed and a global enable.
- Next generation of the single-channel RNG peripheral: adds channel count, buffering, a status register and an underflow flag.
- Sits behind the AXI interconnect next to the other custom IP and is exercised by the AXI VIP master in the BFM design.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8: AXI byte-address width.
- NUM_CH, 4: number of LFSR channels, 1..8.
- FIFO_DEPTH, 8: words per channel FIFO; power of two, 2..64.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT  in  3  ignored / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1

Behaviour:
- Reset: ARESETN low clears state asynchronously. Effects:
  - All AXI outputs, CTRL, STATUS flags, FIFO pointers and counts go to 0.
  - Every LFSR state goes to 1.
- Register map (word aligned):
  - 0x00 CTRL rw: bit0 EN, bit1 IRQ_EN (only with the optional feature).
  - 0x04 STATUS ro: [7:0] per-channel FIFO-empty; [15:8] per-channel FIFO-full; [23:16] per-channel sticky underflow, write-1-to-clear at 0x04.
  - 0x10+4*ch SEED wo: loads the channel LFSR, flushes its FIFO and clears its underflow bit. Seed 0 loads 1.
  - 0x40+4*ch DATA ro: pops the channel FIFO.
  - Unmapped addresses and channel indices >= NUM_CH: reads return 0, writes are ignored, response OKAY.
- Write channel:
  - AWREADY and WREADY are asserted together for one cycle when AWVALID and WVALID are both high and BVALID is low.
  - The register update happens in that cycle. BVALID is set the next cycle with BRESP=OKAY and held until BREADY.
  - One outstanding write at a time.
  - WSTRB byte lanes apply to CTRL and SEED.
- Read channel:
  - ARREADY is asserted for one cycle when ARVALID is high and RVALID is low.
  - RDATA is registered and RVALID rises the next cycle, held until RREADY. RRESP=OKAY.
  - A DATA pop occurs in the ARREADY cycle.
  - DATA read on an empty FIFO returns 0x00000000 and sets that channel's underflow bit.
- LFSR, per channel:
  - In every cycle where EN=1 and the FIFO is not full: push the current state, then state <= lsb ? (state>>1) ^ 0x80200003 : state>>1.
  - FIFO full: the LFSR holds, nothing is pushed.
  - EN=0: the LFSR holds and no pushes occur; pops remain allowed.
- Simultaneous push and pop on the same FIFO in one cycle: both occur and the count is unchanged.
- SEED write concurrent with a DATA pop on the same channel: the flush wins and the read returns the pre-flush head word.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro RNG_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit). irq is registered: irq <= IRQ_EN & |(full flags of channels < NUM_CH). Reset value 0.
  - CTRL bit1 is read/write.
- Not defined: no irq port, and CTRL bit1 reads 0 and ignores writes.

Test Plan:
- Reset, then read 0x00 and 0x04 -> 0x00000000 and 0x000000FF for NUM_CH=8 (all empty); 0x0000000F for NUM_CH=4.
- Write SEED0=0x00000001, write CTRL=1, wait 20 cycles, read 0x40 three times -> 0x00000001, 0x80200003, 0xC0300002.
- Enable with defaults and wait 20 cycles -> STATUS[11:8]=0xF (all full). Eight reads of 0x44 then succeed; a ninth read with CTRL=0 returns 0 and STATUS bit17 is set. Writing 0x00020000 to 0x04 clears it.
- Write SEED1=0 -> first popped word of ch1 is 0x00000001. Two channels with different seeds produce different first words.
- Assert ARESETN low mid-burst while BVALID is high -> BVALID drops immediately; after release the FIFOs are empty and LFSR states restart from 1.
- With RNG_IRQ_EN: CTRL=3, wait until full -> irq=1. Read one word from ch0 -> irq stays 1 (other channels still full). CTRL=1 -> irq=0 the next cycle.
